// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
// Optional hit/miss counters are enabled by defining DCACHE_PERF_CNT_EN.
module dcache #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Den,
    input  logic        DWen,
    input  logic [31:0] DAddr,
    input  logic [31:0] DWriteData,
    output logic [31:0] DReadData,
    output logic        DStall,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
`ifdef DCACHE_PERF_CNT_EN
    output logic [31:0] HitCount,
    output logic [31:0] MissCount,
`endif
    input  logic        MemAck,
    input  logic [31:0] MemRData
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 28 - IDX_W;

    // state  | meaning
    // IDLE   | serve read hits, accept new accesses
    // REFILL | fetch 4 words of the missing line
    // WRITE  | forward one store to memory
    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_e;

    state_e             state_q;
    logic [1:0]         beat_q;
    logic [27:0]        line_q;
    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [31:0]        data_q [LINES][WORDS];
    logic               mem_req_q;
    logic               mem_we_q;
    logic [31:0]        mem_addr_q;
    logic [31:0]        mem_wdata_q;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]        hit_cnt_q;
    logic [31:0]        miss_cnt_q;
`endif

    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [1:0]         req_word;
    logic               rd_hit;
    logic               idle_rd;
    logic [IDX_W-1:0]   wr_idx;
    logic [TAG_W-1:0]   wr_tag;
    logic [1:0]         wr_word;
    logic               wr_hit;
    logic [IDX_W-1:0]   ref_idx;
    logic [TAG_W-1:0]   ref_tag;

    assign req_idx  = DAddr[IDX_W+3:4];
    assign req_tag  = DAddr[31:IDX_W+4];
    assign req_word = DAddr[3:2];
    assign rd_hit   = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign idle_rd  = (state_q == IDLE) && Den && !DWen;

    // Write hit is judged on the latched store address, not the live bus.
    assign wr_idx   = mem_addr_q[IDX_W+3:4];
    assign wr_tag   = mem_addr_q[31:IDX_W+4];
    assign wr_word  = mem_addr_q[3:2];
    assign wr_hit   = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    assign ref_idx  = line_q[IDX_W-1:0];
    assign ref_tag  = line_q[27:IDX_W];

    always_comb begin
        DStall = 1'b0;
        case (state_q)
            IDLE:    DStall = Den && (DWen || !rd_hit);
            REFILL:  DStall = 1'b1;
            WRITE:   DStall = !MemAck;
            default: DStall = 1'b0;
        endcase
        if (!reset) DStall = 1'b0;
    end

    assign DReadData = (reset && idle_rd && rd_hit) ? data_q[req_idx][req_word] : 32'h0;

    assign MemReq   = mem_req_q;
    assign MemWe    = mem_we_q;
    assign MemAddr  = mem_addr_q;
    assign MemWData = mem_wdata_q;
`ifdef DCACHE_PERF_CNT_EN
    assign HitCount  = hit_cnt_q;
    assign MissCount = miss_cnt_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            beat_q      <= 2'd0;
            line_q      <= 28'd0;
            valid_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
`ifdef DCACHE_PERF_CNT_EN
            hit_cnt_q   <= 32'h0;
            miss_cnt_q  <= 32'h0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (Den) begin
                        if (DWen) begin
                            state_q     <= WRITE;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= DAddr;
                            mem_wdata_q <= DWriteData;
                        end else if (!rd_hit) begin
                            state_q          <= REFILL;
                            valid_q[req_idx] <= 1'b0;
                            beat_q           <= 2'd0;
                            line_q           <= DAddr[31:4];
                            mem_req_q        <= 1'b1;
                            mem_we_q         <= 1'b0;
                            mem_addr_q       <= {DAddr[31:4], 4'b0000};
`ifdef DCACHE_PERF_CNT_EN
                            miss_cnt_q       <= miss_cnt_q + 32'd1;
`endif
                        end else begin
`ifdef DCACHE_PERF_CNT_EN
                            hit_cnt_q <= hit_cnt_q + 32'd1;
`endif
                        end
                    end
                end
                REFILL: begin
                    if (MemAck) begin
                        beat_q <= beat_q + 2'd1;
                        if (beat_q == 2'd3) begin
                            state_q          <= IDLE;
                            valid_q[ref_idx] <= 1'b1;
                            mem_req_q        <= 1'b0;
                            mem_addr_q       <= 32'h0;
                        end else begin
                            mem_addr_q <= {line_q, beat_q + 2'd1, 2'b00};
                        end
                    end
                end
                WRITE: begin
                    if (MemAck) begin
                        state_q     <= IDLE;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= 32'h0;
                        mem_wdata_q <= 32'h0;
`ifdef DCACHE_PERF_CNT_EN
                        if (!wr_hit) miss_cnt_q <= miss_cnt_q + 32'd1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag/data arrays carry no reset; the valid bits alone guard them.
    always_ff @(posedge clk) begin
        if (state_q == REFILL && MemAck) begin
            data_q[ref_idx][beat_q] <= MemRData;
            if (beat_q == 2'd3) tag_q[ref_idx] <= ref_tag;
        end
        if (state_q == WRITE && MemAck && wr_hit) begin
            data_q[wr_idx][wr_word] <= mem_wdata_q;
        end
    end

endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache: a reference memory and a small line model predict
// read data, refill beats and latencies; a bus responder checks request stability.
module tb_dcache;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Den = 1'b0;
    logic        DWen = 1'b0;
    logic [31:0] DAddr = 32'h0;
    logic [31:0] DWriteData = 32'h0;
    logic [31:0] DReadData;
    logic        DStall;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic        MemAck;
    logic [31:0] MemRData = 32'hBAD0_BAD0;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] HitCount;
    logic [31:0] MissCount;
`endif

    dcache #(.LINES(16), .WORDS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .Den        (Den),
        .DWen       (DWen),
        .DAddr      (DAddr),
        .DWriteData (DWriteData),
        .DReadData  (DReadData),
        .DStall     (DStall),
        .MemReq     (MemReq),
        .MemWe      (MemWe),
        .MemAddr    (MemAddr),
        .MemWData   (MemWData),
`ifdef DCACHE_PERF_CNT_EN
        .HitCount   (HitCount),
        .MissCount  (MissCount),
`endif
        .MemAck     (MemAck),
        .MemRData   (MemRData)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    logic [31:0] mem     [0:2047];
    logic [31:0] ref_mem [0:2047];

    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic        ack_r = 1'b0;
    logic        spur_ack = 1'b0;
    logic        pend = 1'b0;
    logic        p_we;
    logic [31:0] p_addr, p_wdata;
    int          rd_beats = 0, wr_beats = 0, cyc = 0, last_ack_cyc = 0;
    logic [31:0] last_wr_addr = 32'h0, last_wr_data = 32'h0;
    logic [31:0] beat_addrs[$];
    logic [31:0] exp_q[$];

    logic        model_valid [16];
    logic [23:0] model_tag   [16];
    int          exp_hit = 0, exp_miss = 0;

    assign MemAck = ack_r | spur_ack;

    // Responder: acks after ack_delay idle cycles and checks that a pending request holds still.
    always @(negedge clk) begin
        if (pend && reset) begin
            check_eq("req_hold",   {31'h0, MemReq}, 32'h1);
            check_eq("we_hold",    {31'h0, MemWe}, {31'h0, p_we});
            check_eq("addr_hold",  MemAddr, p_addr);
            check_eq("wdata_hold", MemWData, p_wdata);
        end
        if (!reset || !MemReq || ack_r) begin
            ack_r    = 1'b0;
            wait_cnt = 0;
            MemRData = 32'hBAD0_BAD0;
        end else if (wait_cnt >= ack_delay) begin
            ack_r    = 1'b1;
            MemRData = mem[MemAddr[12:2]];
        end else begin
            wait_cnt++;
        end
        pend    = reset && MemReq && !ack_r;
        p_we    = MemWe;
        p_addr  = MemAddr;
        p_wdata = MemWData;
    end

    always @(posedge clk) begin
        if (reset && MemReq && MemAck) begin
            if (MemWe) begin
                wr_beats++;
                last_wr_addr = MemAddr;
                last_wr_data = MemWData;
                mem[MemAddr[12:2]] = MemWData;
            end else begin
                rd_beats++;
                beat_addrs.push_back(MemAddr);
                last_ack_cyc = cyc;
            end
        end
        cyc++;
    end

    task automatic check_counters(input string tag);
`ifdef DCACHE_PERF_CNT_EN
        check_eq({tag, "_hitcnt"},  HitCount,  32'(exp_hit));
        check_eq({tag, "_misscnt"}, MissCount, 32'(exp_miss));
`endif
    endtask

    // Called at posedge+1; returns at posedge+1 after the access completes.
    task automatic read_op(input logic [31:0] addr, input string tag);
        int   idx, stalls, rb0;
        logic miss;
        idx  = int'(addr[7:4]);
        miss = !(model_valid[idx] && model_tag[idx] == addr[31:8]);
        exp_q.push_back(ref_mem[addr[12:2]]);
        rb0 = rd_beats;
        beat_addrs.delete();
        Den = 1'b1; DWen = 1'b0; DAddr = addr;
        stalls = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk); #1;
            if (!DStall) break;
            stalls++;
            if (n < 199) begin @(posedge clk); #1; end
        end
        check_eq({tag, "_stall"}, {31'h0, DStall}, 32'h0);
        check_eq({tag, "_data"}, DReadData, exp_q.pop_front());
        check_eq({tag, "_beats"}, 32'(rd_beats - rb0), miss ? 32'd4 : 32'd0);
        if (miss) begin
            check_eq({tag, "_lat"}, 32'(cyc), 32'(last_ack_cyc + 1));
            check_eq({tag, "_nbeat"}, 32'(beat_addrs.size()), 32'd4);
            for (int i = 0; i < 4 && beat_addrs.size() > 0; i++)
                check_eq({tag, "_beataddr"}, beat_addrs.pop_front(), {addr[31:4], 4'h0} + 32'(4 * i));
            model_valid[idx] = 1'b1;
            model_tag[idx]   = addr[31:8];
            exp_miss++;
        end else begin
            check_eq({tag, "_hitstall"}, 32'(stalls), 32'd0);
        end
        exp_hit++;
        @(posedge clk); #1;
        Den = 1'b0;
    endtask

    task automatic write_op(input logic [31:0] addr, input logic [31:0] data, input int delay, input string tag);
        int   idx, stalls, wb0, rb0;
        logic miss;
        idx  = int'(addr[7:4]);
        miss = !(model_valid[idx] && model_tag[idx] == addr[31:8]);
        ack_delay = delay;
        wb0 = wr_beats; rb0 = rd_beats;
        Den = 1'b1; DWen = 1'b1; DAddr = addr; DWriteData = data;
        stalls = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk); #1;
            if (!DStall) break;
            stalls++;
            if (n < 199) begin @(posedge clk); #1; end
        end
        check_eq({tag, "_stall"}, {31'h0, DStall}, 32'h0);
        check_eq({tag, "_ackcyc"}, {31'h0, MemAck}, 32'h1);
        check_eq({tag, "_we"}, {31'h0, MemWe}, 32'h1);
        check_eq({tag, "_addr"}, MemAddr, addr);
        check_eq({tag, "_nstall"}, 32'(stalls), 32'(delay + 1));
        @(posedge clk); #1;
        Den = 1'b0; DWen = 1'b0;
        ack_delay = 0;
        check_eq({tag, "_wbeats"}, 32'(wr_beats - wb0), 32'd1);
        check_eq({tag, "_rbeats"}, 32'(rd_beats - rb0), 32'd0);
        check_eq({tag, "_wraddr"}, last_wr_addr, addr);
        check_eq({tag, "_wrdata"}, last_wr_data, data);
        ref_mem[addr[12:2]] = data;
        if (miss) exp_miss++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        logic [31:0] a;
        for (int i = 0; i < 2048; i++) begin
            mem[i]     = 32'h5A00_0000 ^ (32'(i) << 2);
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < 4; i++) begin
            mem[16 + i]     = 32'h11 * 32'(i + 1);
            ref_mem[16 + i] = mem[16 + i];
        end
        for (int i = 0; i < 16; i++) begin
            model_valid[i] = 1'b0;
            model_tag[i]   = 24'h0;
        end

        Den = 1'b1; DAddr = 32'h40;
        #2;
        check_eq("rst_stall", {31'h0, DStall}, 32'h0);
        check_eq("rst_rdata", DReadData, 32'h0);
        check_eq("rst_memreq", {31'h0, MemReq}, 32'h0);
        check_eq("rst_memwe", {31'h0, MemWe}, 32'h0);
        check_eq("rst_memaddr", MemAddr, 32'h0);
        check_eq("rst_memwdata", MemWData, 32'h0);
        Den = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk); #1;
        check_eq("idle_stall", {31'h0, DStall}, 32'h0);
        check_eq("idle_rdata", DReadData, 32'h0);
        check_counters("init");
        @(posedge clk); #1;

        read_op(32'h40, "rd40_miss");
        read_op(32'h4C, "rd4c_hit");
        write_op(32'h44, 32'hDEAD_BEEF, 3, "wr44_hit");
        read_op(32'h44, "rd44_hit");
        check_counters("after_wrhit");

        write_op(32'h1000, 32'h1234_5678, 1, "wr1000_miss");
        read_op(32'h1000, "rd1000_miss");
        check_counters("after_wrmiss");

        ack_delay = 2;
        read_op(32'h140, "rd140_conflict");
        ack_delay = 0;
        read_op(32'h40, "rd40_again");
        read_op(32'h48, "rd48_hit");

        spur_ack = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        spur_ack = 1'b0;
        read_op(32'h44, "rd44_after_spur");
        check_counters("after_spur");

        r0 = rd_beats;
        Den = 1'b1; DWen = 1'b0; DAddr = 32'h200;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (rd_beats - r0 >= 2) break;
        end
        check_eq("abort_beats", 32'(rd_beats - r0), 32'd2);
        reset = 1'b0;
        #1;
        check_eq("abort_memreq", {31'h0, MemReq}, 32'h0);
        check_eq("abort_stall", {31'h0, DStall}, 32'h0);
        check_eq("abort_rdata", DReadData, 32'h0);
        Den = 1'b0;
        for (int i = 0; i < 16; i++) model_valid[i] = 1'b0;
        exp_hit = 0; exp_miss = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        read_op(32'h200, "rd200_after_abort");
        read_op(32'h40, "rd40_after_reset");
        check_counters("after_abort");

        for (int k = 0; k < 16; k++) begin
            a = 32'($urandom_range(0, 255)) << 2;
            if ($urandom_range(0, 2) == 0)
                write_op(a, $urandom, int'($urandom_range(0, 2)), "rnd_wr");
            else
                read_op(a, "rnd_rd");
        end
        check_counters("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 SHALL have parameter LINES, 16, number of direct-mapped lines (power of two).
REQ-002 SHALL have parameter WORDS, 4, 32-bit words per line (fixed at 4).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Den  input  1  datapath access valid.
REQ-006 SHALL have port DWen  input  1  access is a write (qualified by Den).
REQ-007 SHALL have port DAddr  input  32  word-aligned byte address.
REQ-008 SHALL have port DWriteData  input  32  store data.
REQ-009 SHALL have port DReadData  output  32  load data.
REQ-010 SHALL have port DStall  output  1  access not complete; datapath holds Den/DWen/DAddr/DWriteData stable while high.
REQ-011 SHALL have ports MemReq output 1, MemWe output 1, MemAddr output 32, MemWData output 32: backing-memory request.
REQ-012 SHALL have ports MemAck input 1 (one word transferred this cycle) and MemRData input 32.

Function
REQ-013 SHALL split DAddr as: [1:0] ignored, [3:2] word, [log2(LINES)+3:4] index, remainder tag; each line holds a valid bit, tag and 4 words.
REQ-014 SHALL implement FSM states IDLE, REFILL, WRITE.
REQ-015 IDLE, Den=1, DWen=0, hit: DReadData = stored word combinationally, DStall=0, zero added latency.
REQ-016 IDLE, read miss: DStall=1 the same cycle, clear the line's valid bit, beat counter to 0, go to REFILL.
REQ-017 REFILL: MemReq=1, MemWe=0, MemAddr={tag,index,beat,2'b00}; on each MemAck, write MemRData to word[beat] and increment beat; on the 4th ack, set valid, write tag and go to IDLE with DStall still 1; the re-presented read hits the next cycle (miss latency = 4 acks + 1 cycle).
REQ-018 IDLE, Den=1, DWen=1: DStall=1, go to WRITE (write-through, no write-allocate).
REQ-019 WRITE: MemReq=1, MemWe=1, MemAddr=DAddr, MemWData=DWriteData; DStall = !MemAck; on MemAck, if hit, update the cache word, then go to IDLE; a write miss leaves cache contents unchanged.
REQ-020 MemReq, MemWe, MemAddr and MemWData SHALL hold stable from assertion until MemAck; MemReq=0 in IDLE.
REQ-021 Den=0 in IDLE: no state change, DStall=0, DReadData=0; DReadData SHALL also be 0 when not a read hit.
REQ-022 Once REFILL or WRITE is entered, the operation SHALL complete even if Den drops (protocol violation tolerated, result discarded).
REQ-023 MemAck outside REFILL/WRITE SHALL be ignored.

Reset
REQ-024 reset low SHALL immediately force: state IDLE, all valid bits 0, beat 0, DStall=0, DReadData=0, MemReq=0, MemWe=0, MemAddr=0, MemWData=0, counters 0.
REQ-025 reset asserted mid-REFILL/WRITE SHALL abort the transfer; the partially refilled line stays invalid. Tag/data arrays need no reset.

Configuration
REQ-026 Macro DCACHE_PERF_CNT_EN: when defined, add outputs HitCount[31:0] and MissCount[31:0]; HitCount increments once per completed IDLE read hit, MissCount once per REFILL entry and once per write miss; both wrap at 2^32. When undefined, these ports and counters SHALL NOT exist; all other behaviour is identical.

Verification
REQ-027 After reset, read 0x00000040 with memory word[0x40..0x4C]=0x11,0x22,0x33,0x44 -> DStall=1, 4 MemReq beats at 0x40/0x44/0x48/0x4C; the following cycle DReadData=0x11, DStall=0; a read of 0x4C then hits at 0x44 with zero stall.
REQ-028 Write 0xDEADBEEF to 0x44 (line present) with MemAck delayed 3 cycles -> MemReq/MemWe/MemAddr=0x44 held stable 3 cycles, DStall drops in the ack cycle; a read of 0x44 then returns 0xDEADBEEF with no miss.
REQ-029 Write to 0x1000 (absent) -> one memory write, no refill; a read of 0x1000 then misses (MissCount +2 with DCACHE_PERF_CNT_EN).
REQ-030 Conflict: read 0x40, then read 0x140 (same index, LINES=16) -> second read refills; a read of 0x40 misses again.
REQ-031 Assert reset after the 2nd refill ack -> MemReq=0 immediately; after release, a read of that line misses and performs all 4 beats.
